// File: rtl/codec_frame_sched_pkg.sv
// rtl/codec_frame_sched_pkg.sv - shared FSM encoding and frame geometry for the frame scheduler
package codec_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_READ,
    ST_DRAIN
  } sched_state_e;

  localparam int unsigned DEF_ADDR_BITS = 10;
  localparam int unsigned FRAME_LEN     = 1 << DEF_ADDR_BITS;
  // Wide enough for in-flight + FIFO levels with RD_LATENCY up to 4
  localparam int unsigned CNT_BITS      = 4;

  function automatic int unsigned frame_len(input int unsigned addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/codec_sched_fifo.sv
// rtl/codec_sched_fifo.sv - synchronous FIFO with registered output; count_o includes the output register
module codec_sched_fifo
  import codec_frame_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    push_data_i,
  input  logic                ready_i,
  output logic [WIDTH-1:0]    out_data_o,
  output logic                out_valid_o,
  output logic [CNT_BITS-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    load        = (mem_cnt_q != '0) && (!out_valid_q || ready_i);
    wr_ptr_d    = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_cnt_d   = mem_cnt_q + CNT_BITS'(push_i) - CNT_BITS'(load);
    out_d       = load ? mem_q[rd_ptr_q] : out_q;
    out_valid_d = load | (out_valid_q & ~ready_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = mem_cnt_q + CNT_BITS'(out_valid_q);

endmodule

// File: rtl/codec_frame_sched.sv
// rtl/codec_frame_sched.sv - reads one buffer frame per start edge and streams it to the FFT with backpressure
module codec_frame_sched
  import codec_frame_sched_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buff_start_i,
  output logic [ADDR_BITS-1:0] buff_raddr_o,
  input  logic [DATA_BITS-1:0] buff_rdata_i,
  input  logic                 run_i,
  input  logic                 single_i,
  output logic [DATA_BITS-1:0] fft_data_o,
  output logic                 fft_valid_o,
  input  logic                 fft_ready_i,
  output logic                 fft_last_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i,
  output logic [15:0]          frame_cnt_o
);

  localparam int unsigned        DEPTH    = RD_LATENCY + 2;
  localparam logic [ADDR_BITS:0] LAST_IDX = {1'b0, {ADDR_BITS{1'b1}}};

  sched_state_e          state_q, state_d;
  logic                  start_q, oneshot_q, oneshot_d, overrun_q, overrun_d;
  logic [ADDR_BITS:0]    issue_cnt_q, issue_cnt_d;
  logic [ADDR_BITS-1:0]  raddr_q, raddr_d;
  logic [CNT_BITS-1:0]   in_flight_q, in_flight_d, fifo_cnt;
  logic [RD_LATENCY-1:0] vld_pipe_q, last_pipe_q;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  start_edge, issue, issue_last, push, pop, credit_ok, fifo_valid;
  logic [DATA_BITS:0]    fifo_out;

  always_comb begin
    start_edge  = buff_start_i & ~start_q;
    pop         = fifo_valid & fft_ready_i;
    push        = vld_pipe_q[RD_LATENCY-1];
    // A read is admitted only if the FIFO could hold it with no further drain
    credit_ok   = (in_flight_q + fifo_cnt + CNT_BITS'(1)) <= (CNT_BITS'(DEPTH) + CNT_BITS'(pop));
    issue       = (state_q == ST_READ) && credit_ok;
    issue_last  = issue && (issue_cnt_q == LAST_IDX);
    state_d     = state_q;
    oneshot_d   = oneshot_q;
    issue_cnt_d = issue_cnt_q;
    raddr_d     = raddr_q;
    frame_cnt_d = frame_cnt_q;
    in_flight_d = in_flight_q + CNT_BITS'(issue) - CNT_BITS'(push);
    overrun_d   = ovr_clr_i ? 1'b0 : overrun_q;
    if (start_edge && (state_q == ST_READ || state_q == ST_DRAIN)) overrun_d = 1'b1;
    if (issue) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
      if (!issue_last) raddr_d = raddr_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (single_i || run_i) state_d = ST_WAIT_START;
        if (single_i) oneshot_d = 1'b1;
      end
      ST_WAIT_START: begin
        if (start_edge) begin
          state_d     = ST_READ;
          issue_cnt_d = '0;
          raddr_d     = '0;
        end else if (!run_i && !oneshot_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fft_last_o && fft_ready_i) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (run_i && !oneshot_q) begin
            state_d = ST_WAIT_START;
          end else begin
            state_d   = ST_IDLE;
            oneshot_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      oneshot_q   <= 1'b0;
      overrun_q   <= 1'b0;
      issue_cnt_q <= '0;
      raddr_q     <= '0;
      in_flight_q <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= buff_start_i;
      oneshot_q   <= oneshot_d;
      overrun_q   <= overrun_d;
      issue_cnt_q <= issue_cnt_d;
      raddr_q     <= raddr_d;
      in_flight_q <= in_flight_d;
      vld_pipe_q  <= RD_LATENCY'({vld_pipe_q, issue});
      last_pipe_q <= RD_LATENCY'({last_pipe_q, issue_last});
      frame_cnt_q <= frame_cnt_d;
    end
  end

  codec_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({last_pipe_q[RD_LATENCY-1], buff_rdata_i}),
    .ready_i     (fft_ready_i),
    .out_data_o  (fifo_out),
    .out_valid_o (fifo_valid),
    .count_o     (fifo_cnt)
  );

  assign buff_raddr_o = raddr_q;
  assign fft_data_o   = fifo_out[DATA_BITS-1:0];
  assign fft_valid_o  = fifo_valid;
  assign fft_last_o   = fifo_valid & fifo_out[DATA_BITS];
  assign busy_o       = (state_q != ST_IDLE);
  assign overrun_o    = overrun_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_codec_frame_sched.sv
// tb/tb_codec_frame_sched.sv - randomized scoreboard bench for the codec frame scheduler
module tb_codec_frame_sched;
  import codec_frame_sched_pkg::*;

  localparam int AB  = 10;
  localparam int DB  = 16;
  localparam int LAT = 2;
  localparam int N   = int'(frame_len(AB));

  typedef struct packed {
    logic          last;
    logic [DB-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          buff_start_i, run_i, single_i, fft_ready_i, ovr_clr_i;
  logic [AB-1:0] buff_raddr_o;
  logic [DB-1:0] buff_rdata_i, fft_data_o;
  logic          fft_valid_o, fft_last_o, busy_o, overrun_o;
  logic [15:0]   frame_cnt_o;

  logic [DB-1:0] salt;
  logic [DB-1:0] rd_pipe [LAT];
  beat_t         exp_q [$];
  int            tests = 0, fails = 0;
  int            model_frames = 0, seen = 0;
  int            cyc = 0, e0_cyc = 0, last_cyc = 0;
  bit            ready_rand = 1'b0;

  codec_frame_sched #(
    .ADDR_BITS  (AB),
    .DATA_BITS  (DB),
    .RD_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buff_start_i (buff_start_i),
    .buff_raddr_o (buff_raddr_o),
    .buff_rdata_i (buff_rdata_i),
    .run_i        (run_i),
    .single_i     (single_i),
    .fft_data_o   (fft_data_o),
    .fft_valid_o  (fft_valid_o),
    .fft_ready_i  (fft_ready_i),
    .fft_last_o   (fft_last_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .ovr_clr_i    (ovr_clr_i),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DB-1:0] sample_of(input logic [AB-1:0] a, input logic [DB-1:0] s);
    return DB'(a) ^ s;
  endfunction

  // Buffer model: address presented in cycle k yields its data in cycle k+LAT
  always @(posedge clk) begin
    rd_pipe[0] <= sample_of(buff_raddr_o, salt);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign buff_rdata_i = rd_pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    fft_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      fft_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  initial begin
    logic          pv, pr, pl;
    logic [DB-1:0] pd;
    beat_t         e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", fft_valid_o, 1);
          check("hold_beat", {fft_last_o, fft_data_o}, {pl, pd});
        end
        if (fft_valid_o && fft_ready_i) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: actual data %0h last %0b, required no beat", fft_data_o, fft_last_o);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", fft_data_o, e.data);
            check("beat_last", fft_last_o, e.last);
            seen++;
            if (e.last) begin
              check("frame_cnt_at_last", frame_cnt_o, 16'(model_frames));
              model_frames++;
              last_cyc = cyc;
              seen = 0;
            end
          end
        end
        pv = fft_valid_o; pr = fft_ready_i; pd = fft_data_o; pl = fft_last_o;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit expect_frame);
    beat_t b;
    @(posedge clk);
    #1 buff_start_i = 1'b1;
    if (expect_frame) begin
      for (int a = 0; a < N; a++) begin
        b.last = (a == N - 1);
        b.data = sample_of(AB'(a), salt);
        exp_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    e0_cyc = cyc;
    if (expect_frame) check("raddr_first", buff_raddr_o, 0);
    buff_start_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * N) begin
      @(posedge clk);
      k++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d beats pending after %0d cycles, required 0", name, exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  task automatic wait_seen(input int n, input string name);
    int k;
    k = 0;
    while (seen < n && k < 4 * N) begin
      @(posedge clk);
      k++;
    end
    #1;
    tests++;
    if (seen < n) begin
      fails++;
      $display("FAIL %s: saw %0d beats, required %0d", name, seen, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_raddr"}, buff_raddr_o, 0);
    check({tag, "_data"}, fft_data_o, 0);
    check({tag, "_valid"}, fft_valid_o, 0);
    check({tag, "_last"}, fft_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
    check({tag, "_frame_cnt"}, frame_cnt_o, 0);
  endtask

  initial begin
    int k;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; buff_start_i = 1'b0; run_i = 1'b0; single_i = 1'b0; ovr_clr_i = 1'b0; salt = '0;
    tick(4);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(2);
    start_frame(0);
    tick(6);
    check("idle_edge_busy", busy_o, 0);
    check("idle_edge_overrun", overrun_o, 0);

    // Continuous capture, ready held high, data = address
    run_i = 1'b1;
    tick(2);
    check("t1_wait_busy", busy_o, 1);
    start_frame(1);
    k = 0;
    @(negedge clk);
    while (!fft_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t1_first_valid_lat", k, LAT + 2);
    wait_drain("t1_drain");
    check("t1_frame_len", last_cyc - e0_cyc + 1, N + LAT + 2);
    check("t1_frame_cnt", frame_cnt_o, 1);
    check("t1_busy_after", busy_o, 1);

    // Random backpressure, random data
    ready_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      salt = DB'($urandom);
      tick($urandom_range(1, 6));
      start_frame(1);
      wait_drain("t2_drain");
    end
    check("t2_frame_cnt", frame_cnt_o, 3);

    // Overrun: edge mid-frame, clear, then clear together with an edge
    salt = DB'($urandom);
    start_frame(1);
    wait_seen(500, "t3_seen500");
    check("t3_ovr_before", overrun_o, 0);
    start_frame(0);
    check("t3_ovr_set", overrun_o, 1);
    wait_drain("t3_drain");
    check("t3_ovr_sticky", overrun_o, 1);
    ovr_clr_i = 1'b1;
    tick(1);
    ovr_clr_i = 1'b0;
    check("t3_ovr_clr", overrun_o, 0);
    start_frame(1);
    tick(50);
    buff_start_i = 1'b1;
    ovr_clr_i = 1'b1;
    tick(1);
    buff_start_i = 1'b0;
    ovr_clr_i = 1'b0;
    check("t3_set_wins", overrun_o, 1);
    wait_drain("t3_drain2");
    ovr_clr_i = 1'b1;
    tick(1);
    ovr_clr_i = 1'b0;
    check("t3_frame_cnt", frame_cnt_o, 5);

    // Single shot with run low
    run_i = 1'b0;
    tick(3);
    check("t4_idle", busy_o, 0);
    single_i = 1'b1;
    tick(1);
    single_i = 1'b0;
    check("t4_armed", busy_o, 1);
    salt = DB'($urandom);
    start_frame(1);
    wait_drain("t4_drain");
    check("t4_idle_after", busy_o, 0);
    for (int r = 0; r < 2; r++) begin
      tick($urandom_range(2, 8));
      start_frame(0);
      tick(12);
      check("t4_no_overrun", overrun_o, 0);
      check("t4_still_idle", busy_o, 0);
    end
    check("t4_frame_cnt", frame_cnt_o, 6);

    // Reset mid-frame, then a clean restart
    run_i = 1'b1;
    salt = DB'($urandom);
    tick(2);
    start_frame(1);
    wait_seen(300, "t5_seen300");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    seen = 0;
    model_frames = 0;
    check_reset_outputs("t5");
    rst = 1'b0;
    tick(2);
    start_frame(1);
    wait_drain("t5_drain");
    check("t5_frame_cnt", frame_cnt_o, 1);

    // run dropped mid-frame: frame completes, then IDLE
    salt = DB'($urandom);
    start_frame(1);
    wait_seen(10, "t6_seen10");
    run_i = 1'b0;
    wait_drain("t6_drain");
    check("t6_idle", busy_o, 0);
    check("t6_frame_cnt", frame_cnt_o, 2);

    ready_rand = 1'b0;
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
